// File: rtl/irq_requester.sv
// irq_requester: external interrupt source for the single-cycle LEGv8 core.
// Edge-detects NSRC peripheral lines, latches them as pending, and picks a
// source by fixed priority (index 0 highest). It raises ExtIRQ toward the
// controller, holds the request until ExtIAck, then waits for ERet before
// starting the next request.
module irq_requester #(
    parameter int NSRC = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            ExtIAck,
    input  logic            ERet,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] irq_pending,
    output logic            busy,
    output logic [CNTW-1:0] lost_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [CNTW-1:0] lost_q, lost_d;
    logic            ext_irq_q;
    logic [IDW-1:0]  irq_id_q;
    logic            busy_q;

    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] lost_hit;
    logic            ack_fire;
    logic            any_req;
    logic [IDW-1:0]  sel_id;

    assign edge_det = irq_src & ~src_q;
    assign ack_fire = (state_q == REQ) && ExtIAck;

    // Pending update and lost-event count. A new edge wins over the ack
    // clear, so an event that arrives while its own ack is taken is not lost.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr[i] = ack_fire && (irq_id_q == IDW'(i));
        end
        pend_d   = (pend_q & ~clr) | edge_det;
        lost_hit = edge_det & pend_q & ~clr;
        lost_d   = lost_q;
        if ((|lost_hit) && (lost_q != {CNTW{1'b1}})) begin
            lost_d = lost_q + 1'b1;
        end
    end

    // Fixed-priority pick among enabled pending sources, lowest index first.
    always_comb begin
        any_req = |(pend_q & irq_mask);
        sel_id  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_q[i] && irq_mask[i]) begin
                sel_id = IDW'(i);
            end
        end
    end

    // Edge-detect history, pending register and lost counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            src_q  <= irq_src;
            pend_q <= pend_d;
            lost_q <= lost_d;
        end
    end

    // Request FSM with registered ExtIRQ, irq_id and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ext_irq_q <= 1'b0;
            irq_id_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= REQ;
                        irq_id_q  <= sel_id;
                        ext_irq_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (ExtIAck) begin
                        state_q   <= SERVICE;
                        ext_irq_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (ERet) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ext_irq_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ExtIRQ      = ext_irq_q;
    assign irq_id      = irq_id_q;
    assign irq_pending = pend_q;
    assign busy        = busy_q;
    assign lost_cnt    = lost_q;

endmodule

// File: tb/tb_irq_requester.sv
// Bench for irq_requester: expected grant ids are queued as stimulus is
// driven and popped when ExtIRQ rises; other checks are inline per scenario.
module tb_irq_requester;

    logic       clk, reset;
    logic [3:0] irq_src, irq_mask;
    logic       ExtIAck, ERet;
    logic       ExtIRQ, busy;
    logic [1:0] irq_id;
    logic [3:0] irq_pending;
    logic [7:0] lost_cnt;

    logic       s_ExtIRQ, s_busy;
    logic [1:0] s_irq_id;
    logic [3:0] s_pending;
    logic [1:0] s_lost;

    int nchk = 0;
    int nerr = 0;
    int exp_q[$];

    irq_requester #(.NSRC(4), .IDW(2), .CNTW(8)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .irq_mask(irq_mask),
        .ExtIAck(ExtIAck), .ERet(ERet), .ExtIRQ(ExtIRQ), .irq_id(irq_id),
        .irq_pending(irq_pending), .busy(busy), .lost_cnt(lost_cnt)
    );

    irq_requester #(.NSRC(4), .IDW(2), .CNTW(2)) dut_sat (
        .clk(clk), .reset(reset), .irq_src(irq_src), .irq_mask(irq_mask),
        .ExtIAck(ExtIAck), .ERet(ERet), .ExtIRQ(s_ExtIRQ), .irq_id(s_irq_id),
        .irq_pending(s_pending), .busy(s_busy), .lost_cnt(s_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        irq_src  = '0;
        irq_mask = 4'hF;
        ExtIAck  = 1'b0;
        ERet     = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_ack();
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
    endtask

    task automatic do_eret();
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_src = v;
        tick();
        irq_src = '0;
        tick();
    endtask

    // Wait up to budget clocks for ExtIRQ, then compare irq_id with the queue head.
    task automatic wait_req(input int budget);
        int n;
        int e;
        n = 0;
        while (ExtIRQ !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        nchk++;
        if (ExtIRQ !== 1'b1) begin
            nerr++;
            $display("FAIL wait_req: ExtIRQ=%b after %0d clocks, required 1", ExtIRQ, budget);
        end else if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL wait_req: unexpected request irq_id=%0d, none queued", irq_id);
        end else begin
            e = exp_q.pop_front();
            if (irq_id !== 2'(e)) begin
                nerr++;
                $display("FAIL grant_id: irq_id=%0d, required %0d", irq_id, e);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        nchk++; if (ExtIRQ !== 1'b0) begin nerr++; $display("FAIL reset_extirq: %b want 0", ExtIRQ); end
        nchk++; if (irq_id !== 2'd0) begin nerr++; $display("FAIL reset_id: %0d want 0", irq_id); end
        nchk++; if (irq_pending !== 4'h0) begin nerr++; $display("FAIL reset_pending: %b want 0000", irq_pending); end
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: %b want 0", busy); end
        nchk++; if (lost_cnt !== 8'd0) begin nerr++; $display("FAIL reset_lost: %0d want 0", lost_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        nchk++; if (irq_pending !== 4'b0100) begin nerr++; $display("FAIL basic_pending: %b want 0100", irq_pending); end
        nchk++; if (ExtIRQ !== 1'b0) begin nerr++; $display("FAIL basic_early: ExtIRQ=%b want 0", ExtIRQ); end
        exp_q.push_back(2);
        tick();
        wait_req(0);
        nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy_req: %b want 1", busy); end
        do_ack();
        nchk++; if (irq_pending !== 4'b0000) begin nerr++; $display("FAIL basic_clear: %b want 0000", irq_pending); end
        nchk++; if (ExtIRQ !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL basic_service: ExtIRQ=%b busy=%b want 0/1", ExtIRQ, busy); end
        do_eret();
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_priority();
        do_reset();
        exp_q.push_back(1);
        exp_q.push_back(3);
        pulse(4'b1010);
        wait_req(0);
        do_ack();
        nchk++; if (irq_pending !== 4'b1000) begin nerr++; $display("FAIL prio_pending: %b want 1000", irq_pending); end
        do_eret();
        nchk++; if (ExtIRQ !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL prio_gap: ExtIRQ=%b busy=%b want 0/0", ExtIRQ, busy); end
        tick();
        wait_req(0);
        do_ack();
        do_eret();
    endtask

    task automatic test_mask();
        do_reset();
        irq_mask = 4'b1110;
        pulse(4'b0001);
        tick();
        nchk++; if (irq_pending !== 4'b0001) begin nerr++; $display("FAIL mask_pending: %b want 0001", irq_pending); end
        nchk++; if (ExtIRQ !== 1'b0) begin nerr++; $display("FAIL mask_blocked: ExtIRQ=%b want 0", ExtIRQ); end
        irq_mask = 4'b1111;
        exp_q.push_back(0);
        wait_req(2);
        do_ack();
        do_eret();
    endtask

    task automatic test_lost();
        do_reset();
        exp_q.push_back(1);
        pulse(4'b0010);
        wait_req(0);
        for (int k = 0; k < 3; k++) pulse(4'b0010);
        nchk++; if (lost_cnt !== 8'd3) begin nerr++; $display("FAIL lost_3: %0d want 3", lost_cnt); end
        nchk++; if (s_lost !== 2'd3) begin nerr++; $display("FAIL lost_sat3: %0d want 3", s_lost); end
        for (int k = 0; k < 2; k++) pulse(4'b0010);
        nchk++; if (lost_cnt !== 8'd5) begin nerr++; $display("FAIL lost_5: %0d want 5", lost_cnt); end
        nchk++; if (s_lost !== 2'd3) begin nerr++; $display("FAIL lost_saturate: %0d want 3", s_lost); end
        nchk++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin nerr++; $display("FAIL lost_held: ExtIRQ=%b id=%0d want 1/1", ExtIRQ, irq_id); end
        pulse(4'b1000);
        nchk++; if (irq_pending !== 4'b1010 || lost_cnt !== 8'd5) begin nerr++; $display("FAIL lost_new: pend=%b lost=%0d want 1010/5", irq_pending, lost_cnt); end
        pulse(4'b1010);
        nchk++; if (lost_cnt !== 8'd6) begin nerr++; $display("FAIL lost_multi: %0d want 6", lost_cnt); end
        do_ack();
        do_eret();
        exp_q.push_back(3);
        wait_req(3);
        do_ack();
        do_eret();
    endtask

    task automatic test_ack_collision();
        do_reset();
        exp_q.push_back(0);
        pulse(4'b0001);
        wait_req(0);
        ExtIAck = 1'b1;
        irq_src = 4'b0001;
        tick();
        ExtIAck = 1'b0;
        irq_src = '0;
        nchk++; if (irq_pending !== 4'b0001) begin nerr++; $display("FAIL coll_pending: %b want 0001", irq_pending); end
        nchk++; if (lost_cnt !== 8'd0) begin nerr++; $display("FAIL coll_lost: %0d want 0", lost_cnt); end
        nchk++; if (ExtIRQ !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL coll_service: ExtIRQ=%b busy=%b want 0/1", ExtIRQ, busy); end
        do_eret();
        exp_q.push_back(0);
        tick();
        wait_req(0);
        do_ack();
        do_eret();
    endtask

    task automatic test_ignored();
        do_reset();
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
        nchk++; if (busy !== 1'b0 || ExtIRQ !== 1'b0) begin nerr++; $display("FAIL ign_ack_idle: busy=%b ExtIRQ=%b want 0/0", busy, ExtIRQ); end
        exp_q.push_back(2);
        pulse(4'b0100);
        wait_req(0);
        do_eret();
        nchk++; if (ExtIRQ !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL ign_eret_req: ExtIRQ=%b busy=%b want 1/1", ExtIRQ, busy); end
        ExtIAck = 1'b1;
        ERet    = 1'b1;
        tick();
        ExtIAck = 1'b0;
        ERet    = 1'b0;
        nchk++; if (ExtIRQ !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL ign_both: ExtIRQ=%b busy=%b want 0/1", ExtIRQ, busy); end
        do_ack();
        nchk++; if (busy !== 1'b1 || ExtIRQ !== 1'b0) begin nerr++; $display("FAIL ign_ack_svc: busy=%b ExtIRQ=%b want 1/0", busy, ExtIRQ); end
        do_eret();
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL ign_exit: busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        exp_q.push_back(2);
        pulse(4'b0100);
        irq_src = 4'b0100;
        wait_req(0);
        #2;
        reset = 1'b1;
        #1;
        nchk++; if (ExtIRQ !== 1'b0 || busy !== 1'b0 || irq_pending !== 4'h0) begin
            nerr++; $display("FAIL async_reset: ExtIRQ=%b busy=%b pend=%b want 0/0/0000", ExtIRQ, busy, irq_pending);
        end
        tick();
        reset = 1'b0;
        tick();
        nchk++; if (irq_pending !== 4'b0100 || ExtIRQ !== 1'b0) begin nerr++; $display("FAIL async_edge: pend=%b ExtIRQ=%b want 0100/0", irq_pending, ExtIRQ); end
        exp_q.push_back(2);
        tick();
        wait_req(0);
        irq_src = '0;
        do_ack();
        do_eret();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_lost();
        test_ack_collision();
        test_ignored();
        test_async_reset();
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/irq_requester.md
Name: irq_requester

Overview:
- External interrupt source for the single-cycle LEGv8 core.
- Collects NSRC peripheral interrupt lines, edge-detects them, latches them as pending, arbitrates by fixed priority and drives the controller's ExtIRQ input.
- Holds a request until the controller answers on ExtIAck, then waits for ERet before starting the next request.
- Sits between the peripherals and the controller/exception-vector logic; irq_id lets software identify which source is being serviced.

Parameters:
- NSRC, 4, number of interrupt source lines; index 0 has the highest priority.
- IDW, 2, width of irq_id; must satisfy 2^IDW >= NSRC.
- CNTW, 8, width of the lost-interrupt counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  NSRC  peripheral interrupt lines; level in, rising edge is the event.
- irq_mask  input  NSRC  1 = source enabled for arbitration.
- ExtIAck  input  1  acknowledge from the controller (ExcAck && ExtIRQ).
- ERet  input  1  exception return from the controller; ends service.
- ExtIRQ  output  1  interrupt request to the controller; registered.
- irq_id  output  IDW  index of the source being requested/serviced; registered.
- irq_pending  output  NSRC  pending register, visible for status.
- busy  output  1  1 in REQ or SERVICE.
- lost_cnt  output  CNTW  saturating count of events dropped because the source was already pending.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - ExtIRQ = 0, irq_id = 0, irq_pending = 0, busy = 0, lost_cnt = 0.
  - Internal src_q = 0, so a line already high at reset release counts as an edge on the first clock.
- Edge detect:
  - src_q <= irq_src every cycle.
  - edge[i] = irq_src[i] & ~src_q[i].
- Pending, per bit, each cycle:
  - Set on edge[i]; set is independent of irq_mask.
  - Clear when the ack condition in REQ targets i.
  - Set and clear on the same bit in the same cycle: set wins, bit stays 1.
- Lost events:
  - edge[i] while pending[i] = 1 and not cleared this cycle: lost_cnt += 1.
  - Saturates at 2^CNTW-1.
  - Several lost edges in one cycle count as 1.
- FSM (IDLE, REQ, SERVICE):
  - IDLE: if (pending & mask) != 0, latch irq_id = lowest set index and go to REQ. Otherwise stay. ExtIRQ = 0.
  - REQ: ExtIRQ = 1 and irq_id held stable. Mask or pending changes do not withdraw or change the request. On ExtIAck = 1: clear pending[irq_id], go to SERVICE; ExtIRQ = 0 from the next cycle.
  - SERVICE: ExtIRQ = 0, irq_id held. On ERet = 1, go to IDLE.
- Ignored inputs:
  - ExtIAck outside REQ is ignored.
  - ERet outside SERVICE is ignored.
  - ExtIAck and ERet together in REQ: only the ack is taken.
- Latency:
  - Edge sampled at clock k gives pending set after k.
  - ExtIRQ = 1 after clock k+1 if idle and the source is enabled.
  - At least one IDLE cycle always separates SERVICE from the next REQ.
- Masked pending bits are retained and serviced once unmasked.
- Width rule: irq_id is the zero-extended index; indices >= NSRC are never produced.

Test Plan:
- Reset released with irq_src = 0, mask = all 1s, pulse irq_src[2] for 1 cycle -> pending = 0100 after that clock, ExtIRQ = 1 and irq_id = 2 one clock later; ExtIAck = 1 -> pending = 0, ExtIRQ = 0 next cycle, busy = 1; ERet = 1 -> IDLE, busy = 0.
- Edges on sources 1 and 3 in the same cycle -> irq_id = 1 served first; after ERet and one IDLE cycle, ExtIRQ = 1 with irq_id = 3.
- mask = 1110, edge on source 0 -> pending[0] = 1, ExtIRQ stays 0; set mask = 1111 -> ExtIRQ = 1, irq_id = 0 two clocks after the mask change at the latest.
- Source 1 pending and unacked, three more rising edges on source 1 -> lost_cnt = 3; with CNTW = 2 and five lost edges -> lost_cnt = 3 (saturated).
- Edge on source 0 in the same cycle as ExtIAck for irq_id = 0 -> pending[0] remains 1 and lost_cnt unchanged; after ERet, a new request with irq_id = 0.
- Assert reset asynchronously mid-REQ -> ExtIRQ, busy and pending go to 0 immediately, without waiting for a clock edge; irq_src held high through release -> request after two clocks.
